action_table_mc: RTL
====================

ACTION_TABLE_MC -- requirements
Module: action_table_mc

Interface
REQ-001 Parameter ENTRIES, default 16: number of action entries; IDX_W = clog2(ENTRIES).
REQ-002 Parameter ACTION_W, default 64: action word width.
REQ-003 Parameter LANES, default 2: independent lookup lanes.
REQ-004 Parameter CNT_W, default 32: per-entry hit counter and miss counter width.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 lk_valid  in  LANES  lookup request per lane, from TCAM.
REQ-008 lk_ready  out  LANES  lane accepts lookup.
REQ-009 lk_hit  in  LANES  TCAM hit flag per lane.
REQ-010 lk_index  in  LANES*IDX_W  hit index; lane i occupies bits [i*IDX_W +: IDX_W].
REQ-011 act_valid  out  LANES  action result valid.
REQ-012 act_ready  in  LANES  downstream accepts result.
REQ-013 act_data  out  LANES*ACTION_W  action word per lane.
REQ-014 act_hit  out  LANES  result came from a table entry (1) or from the default action (0).
REQ-015 wr_en, wr_addr[IDX_W], wr_data[ACTION_W]  in  control-plane entry write.
REQ-016 wr_default, default_data[ACTION_W]  in  control-plane default-action write.
REQ-017 cnt_rd_en, cnt_rd_addr[IDX_W], cnt_rd_clr  in  counter read request; clr = read-and-clear.
REQ-018 cnt_rd_valid  out  1  and cnt_rd_data  out  CNT_W  counter read response.
REQ-019 miss_cnt  out  CNT_W  saturating count of accepted misses across all lanes.

Function
REQ-020 Lookup accepted on lane i when lk_valid[i] && lk_ready[i]; result is presented on act_* exactly 1 cycle later if the lane output is empty or draining.
REQ-021 Result = mem[lk_index] with act_hit=1 on hit; default action with act_hit=0 on miss.
REQ-022 Write bypass: wr_en in the same cycle as an accepted hit with wr_addr == lk_index returns wr_data; wr_default with a simultaneous miss returns default_data.
REQ-023 Each lane has an output register plus a 2-entry skid buffer; lk_ready[i] = skid buffer not full; registered, no combinational path from act_ready.
REQ-024 act_valid/act_data hold stable while act_valid && !act_ready; results on a lane leave in acceptance order; there is no ordering between lanes.
REQ-025 Sustained throughput is 1 result per lane per cycle when act_ready is held at 1.
REQ-026 Per-entry hit counter increments by the number of lanes accepting a hit to that entry in the cycle (0..LANES), saturating at 2^CNT_W-1.
REQ-027 miss_cnt increments by the number of lanes accepting a miss, saturating.
REQ-028 Counter read: cnt_rd_valid asserts 1 cycle after cnt_rd_en with the pre-update value; if cnt_rd_clr, counter becomes that cycle's increment (not 0).
REQ-029 Entry writes do not disturb results already registered or buffered.
REQ-030 Multiple lanes hitting the same index in one cycle each receive identical data.

Reset
REQ-031 On rst_n low: act_valid=0, skid buffers empty, lk_ready=0 during reset and 1 on the first cycle after release, cnt_rd_valid=0, all hit counters and miss_cnt=0, default action=0.
REQ-032 Action memory contents are not reset; act_data value is don't-care while act_valid=0.
REQ-033 Reset asserted mid-stream discards all in-flight results with no partial output.

Structure
REQ-034 Package action_pkg holds default parameter values, the IDX_W derivation function and the saturating-add helper.
REQ-035 One sub-module, action_skid (parametrised width, 2 entries), is instantiated once per lane.

Verification
REQ-036 Write entry 3 = 0xAA, lane0 hit idx 3 -> act_data=0xAA, act_hit=1, 1 cycle later.
REQ-037 wr_en addr 5 = 0x55 in the same cycle as a lane1 hit idx 5 (old value 0x11) -> result 0x55.
REQ-038 act_ready=0 for 4 cycles with lk_valid=1 -> lk_ready drops after 3 accepts, no loss or duplication, in-order drain.
REQ-039 Both lanes hit idx 2 for 10 cycles, then read-clear with a concurrent double hit -> read 20, counter = 2; miss_cnt saturates at 2^CNT_W-1 with CNT_W=4.
REQ-040 Assert rst_n low with 3 results buffered -> act_valid=0 immediately, counters=0, no stale output after release.

Source files
------------

// File: rtl/action_pkg.sv
// Shared defaults and helpers for the multi-lane action table.
// Holds the index-width derivation and the saturating counter add.
package action_pkg;

    localparam int ENTRIES_DEF  = 16;
    localparam int ACTION_W_DEF = 64;
    localparam int LANES_DEF    = 2;
    localparam int CNT_W_DEF    = 32;

    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    // Saturates at 2^w-1; the wrap test also covers the full 64-bit case.
    function automatic logic [63:0] sat_add(input logic [63:0] cur, input logic [63:0] inc,
                                            input int w);
        logic [63:0] max_v;
        logic [63:0] sum;
        max_v = {64{1'b1}} >> (64 - w);
        sum   = cur + inc;
        if ((sum < cur) || (sum > max_v)) return max_v;
        return sum;
    endfunction

endpackage

// File: rtl/action_skid.sv
// One lane of result buffering: output register plus a 2-entry skid buffer, in order.
// Latency 1 cycle when the output is free; o_rdy is registered and drops when the skid buffer fills.
module action_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_rdy,
    output logic         o_vld,
    input  logic         i_rdy,
    output logic [W-1:0] o_dat
);

    logic [W-1:0] r_buf [2];
    logic [W-1:0] r_out_dat;
    logic [1:0]   r_cnt;
    logic         r_out_vld;
    logic         r_rdy;

    logic         w_out_free;
    logic         w_pop;
    logic         w_push;
    logic         w_wr_sel;
    logic [1:0]   w_cnt_nxt;

    assign w_out_free = !r_out_vld || i_rdy;
    assign w_pop      = w_out_free && (r_cnt != 2'd0);
    // Incoming data bypasses the buffer only when nothing older is waiting.
    assign w_push     = i_vld && !(w_out_free && (r_cnt == 2'd0));
    assign w_wr_sel   = (r_cnt == 2'd2) || ((r_cnt == 2'd1) && !w_pop);
    assign w_cnt_nxt  = r_cnt - {1'b0, w_pop} + {1'b0, w_push};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_cnt     <= 2'd0;
            r_rdy     <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_rdy <= (w_cnt_nxt != 2'd2);
            if (w_out_free) r_out_vld <= (r_cnt != 2'd0) || i_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (w_out_free) r_out_dat <= (r_cnt != 2'd0) ? r_buf[0] : i_dat;
        if (w_pop)      r_buf[0]  <= r_buf[1];
        if (w_push)     r_buf[w_wr_sel] <= i_dat;
    end

    assign o_rdy = r_rdy;
    assign o_vld = r_out_vld;
    assign o_dat = r_out_dat;

endmodule

// File: rtl/action_table_mc.sv
// Multi-lane action lookup behind a TCAM, with per-entry hit counters and a miss counter.
// Results appear 1 cycle after acceptance; each lane absorbs 3 results of downstream stall.
module action_table_mc
    import action_pkg::*;
#(
    parameter  int ENTRIES  = ENTRIES_DEF,
    parameter  int ACTION_W = ACTION_W_DEF,
    parameter  int LANES    = LANES_DEF,
    parameter  int CNT_W    = CNT_W_DEF,
    localparam int IDX_W    = idx_w(ENTRIES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES-1:0]          lk_valid,
    output logic [LANES-1:0]          lk_ready,
    input  logic [LANES-1:0]          lk_hit,
    input  logic [LANES*IDX_W-1:0]    lk_index,
    output logic [LANES-1:0]          act_valid,
    input  logic [LANES-1:0]          act_ready,
    output logic [LANES*ACTION_W-1:0] act_data,
    output logic [LANES-1:0]          act_hit,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_addr,
    input  logic [ACTION_W-1:0]       wr_data,
    input  logic                      wr_default,
    input  logic [ACTION_W-1:0]       default_data,
    input  logic                      cnt_rd_en,
    input  logic [IDX_W-1:0]          cnt_rd_addr,
    input  logic                      cnt_rd_clr,
    output logic                      cnt_rd_valid,
    output logic [CNT_W-1:0]          cnt_rd_data,
    output logic [CNT_W-1:0]          miss_cnt
);

    logic [ACTION_W-1:0] r_mem [ENTRIES];
    logic [ACTION_W-1:0] r_default;
    logic [CNT_W-1:0]    r_hit_cnt [ENTRIES];
    logic [CNT_W-1:0]    r_miss_cnt;
    logic [CNT_W-1:0]    r_rd_dat;
    logic                r_rd_vld;

    logic [LANES-1:0]    w_acc;
    logic [IDX_W-1:0]    w_idx [LANES];
    logic [ACTION_W-1:0] w_res [LANES];
    logic [ACTION_W:0]   w_out [LANES];
    logic [31:0]         w_hit_inc [ENTRIES];
    logic [31:0]         w_miss_inc;

    assign w_acc = lk_valid & lk_ready;

    // Result selection with same-cycle write bypass, plus per-cycle counter increments.
    always_comb begin
        w_miss_inc = '0;
        for (int e = 0; e < ENTRIES; e++) w_hit_inc[e] = '0;
        for (int l = 0; l < LANES; l++) begin
            w_idx[l] = lk_index[l*IDX_W +: IDX_W];
            if (lk_hit[l])
                w_res[l] = (wr_en && (wr_addr == w_idx[l])) ? wr_data : r_mem[w_idx[l]];
            else
                w_res[l] = wr_default ? default_data : r_default;
            if (w_acc[l]) begin
                if (lk_hit[l]) w_hit_inc[w_idx[l]] = w_hit_inc[w_idx[l]] + 32'd1;
                else           w_miss_inc = w_miss_inc + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) r_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_default  <= '0;
            r_miss_cnt <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_dat   <= '0;
            for (int e = 0; e < ENTRIES; e++) r_hit_cnt[e] <= '0;
        end else begin
            if (wr_default) r_default <= default_data;
            r_miss_cnt <= CNT_W'(sat_add(64'(r_miss_cnt), 64'(w_miss_inc), CNT_W));
            r_rd_vld   <= cnt_rd_en;
            if (cnt_rd_en) r_rd_dat <= r_hit_cnt[cnt_rd_addr];
            // Read-and-clear keeps this cycle's hits rather than dropping them.
            for (int e = 0; e < ENTRIES; e++) begin
                if (cnt_rd_en && cnt_rd_clr && (cnt_rd_addr == IDX_W'(e)))
                    r_hit_cnt[e] <= CNT_W'(sat_add(64'd0, 64'(w_hit_inc[e]), CNT_W));
                else
                    r_hit_cnt[e] <= CNT_W'(sat_add(64'(r_hit_cnt[e]), 64'(w_hit_inc[e]), CNT_W));
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        action_skid #(.W(ACTION_W + 1)) u_skid (
            .clk   (clk),
            .rst_n (rst_n),
            .i_vld (w_acc[l]),
            .i_dat ({lk_hit[l], w_res[l]}),
            .o_rdy (lk_ready[l]),
            .o_vld (act_valid[l]),
            .i_rdy (act_ready[l]),
            .o_dat (w_out[l])
        );
        assign act_data[l*ACTION_W +: ACTION_W] = w_out[l][ACTION_W-1:0];
        assign act_hit[l]                       = w_out[l][ACTION_W];
    end

    assign cnt_rd_valid = r_rd_vld;
    assign cnt_rd_data  = r_rd_dat;
    assign miss_cnt     = r_miss_cnt;

endmodule
